// File: rtl/hex_entry_ctrl.sv
// Hex entry controller: debounced pushbuttons build a 24-bit value nibble by nibble and commit it
// to the display / matrix path. Optional backspace key is enabled with `define HEX_ENTRY_BACKSPACE_EN.
module hex_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TOGGLE_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw_nibble,
  input  logic        key_load_n,
  input  logic        key_commit_n,
  input  logic        key_clear_n,
`ifdef HEX_ENTRY_BACKSPACE_EN
  input  logic        key_back_n,
`endif
  input  logic        auto_sel,
  output logic [3:0]  HEX0a,
  output logic [3:0]  HEX1a,
  output logic [3:0]  HEX2a,
  output logic [3:0]  HEX3a,
  output logic [3:0]  HEX4a,
  output logic [3:0]  HEX5a,
  output logic [3:0]  HEX0b,
  output logic [3:0]  HEX1b,
  output logic [3:0]  HEX2b,
  output logic [3:0]  HEX3b,
  output logic [3:0]  HEX4b,
  output logic [3:0]  HEX5b,
  output logic        select,
  output logic [23:0] value_out,
  output logic        value_valid,
  output logic [2:0]  digit_count,
  output logic        full
);

`ifdef HEX_ENTRY_BACKSPACE_EN
  localparam int NK = 4;
`else
  localparam int NK = 3;
`endif
  localparam int K_LOAD   = 0;
  localparam int K_COMMIT = 1;
  localparam int K_CLEAR  = 2;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TW = $clog2(TOGGLE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TG_MAX = TW'(TOGGLE_CYCLES - 1);

  logic [NK-1:0] w_raw_n;
  logic [NK-1:0] w_press;

`ifdef HEX_ENTRY_BACKSPACE_EN
  assign w_raw_n = {key_back_n, key_clear_n, key_commit_n, key_load_n};
`else
  assign w_raw_n = {key_clear_n, key_commit_n, key_load_n};
`endif

  for (genvar k = 0; k < NK; k++) begin : g_key
    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_db_q;
    logic          r_arm;
    logic [DW-1:0] r_cnt;

    // Synchronizer resets to "pressed" and the key is only armed once a released level is seen,
    // so a key held through reset cannot generate a press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b1;
        r_db_q <= 1'b1;
        r_arm  <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1   <= w_raw_n[k];
        r_s2   <= r_s1;
        r_db_q <= r_db;
        if (r_s2) r_arm <= 1'b1;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_MAX) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[k] = r_arm & r_db_q & ~r_db;
  end

  logic w_clear_ev;
  logic w_commit_ev;
  logic w_load_ev;
  logic w_back_ev;

  assign w_clear_ev  = w_press[K_CLEAR];
  assign w_commit_ev = w_press[K_COMMIT] & ~w_clear_ev;
`ifdef HEX_ENTRY_BACKSPACE_EN
  assign w_back_ev   = w_press[3] & ~w_press[K_COMMIT] & ~w_clear_ev;
`else
  assign w_back_ev   = 1'b0;
`endif
  assign w_load_ev   = w_press[K_LOAD] & ~w_press[K_COMMIT] & ~w_clear_ev & ~w_back_ev;

  logic [23:0] r_entry;
  logic [23:0] r_value;
  logic [2:0]  r_count;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
      r_value <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_commit_ev;
      if (w_clear_ev) begin
        r_entry <= '0;
        r_count <= '0;
      end else if (w_commit_ev) begin
        r_value <= r_entry;
        r_entry <= '0;
        r_count <= '0;
      end else if (w_back_ev) begin
        if (r_count != 3'd0) begin
          r_entry <= {4'h0, r_entry[23:4]};
          r_count <= r_count - 3'd1;
        end
      end else if (w_load_ev) begin
        if (r_count != 3'd6) begin
          r_entry <= {r_entry[19:0], sw_nibble};
          r_count <= r_count + 3'd1;
        end
      end
    end
  end

  logic [TW-1:0] r_tcnt;
  logic          r_sel;

  // A commit shows the b set at once and restarts the toggle period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_sel  <= 1'b0;
    end else if (!auto_sel) begin
      r_tcnt <= '0;
      r_sel  <= 1'b0;
    end else if (w_commit_ev) begin
      r_tcnt <= '0;
      r_sel  <= 1'b1;
    end else if (r_tcnt == TG_MAX) begin
      r_tcnt <= '0;
      r_sel  <= ~r_sel;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign HEX0a       = r_entry[3:0];
  assign HEX1a       = r_entry[7:4];
  assign HEX2a       = r_entry[11:8];
  assign HEX3a       = r_entry[15:12];
  assign HEX4a       = r_entry[19:16];
  assign HEX5a       = r_entry[23:20];
  assign HEX0b       = r_value[3:0];
  assign HEX1b       = r_value[7:4];
  assign HEX2b       = r_value[11:8];
  assign HEX3b       = r_value[15:12];
  assign HEX4b       = r_value[19:16];
  assign HEX5b       = r_value[23:20];
  assign select      = r_sel;
  assign value_out   = r_value;
  assign value_valid = r_valid;
  assign digit_count = r_count;
  assign full        = (r_count == 3'd6);

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed bench for hex_entry_ctrl with short debounce/toggle periods; covers the optional
// backspace key when HEX_ENTRY_BACKSPACE_EN is defined.
module tb_hex_entry_ctrl;

  localparam int OP_LOAD   = 0;
  localparam int OP_COMMIT = 1;
  localparam int OP_CLEAR  = 2;
  localparam int OP_CLRCM  = 3;
  localparam int OP_BACK   = 4;
  localparam int HOLD      = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw_nibble;
  logic        key_load_n;
  logic        key_commit_n;
  logic        key_clear_n;
  logic        key_back_n;
  logic        auto_sel;
  logic [3:0]  HEX0a, HEX1a, HEX2a, HEX3a, HEX4a, HEX5a;
  logic [3:0]  HEX0b, HEX1b, HEX2b, HEX3b, HEX4b, HEX5b;
  logic        select;
  logic [23:0] value_out;
  logic        value_valid;
  logic [2:0]  digit_count;
  logic        full;

  logic [23:0] hexa_w;
  logic [23:0] hexb_w;
  assign hexa_w = {HEX5a, HEX4a, HEX3a, HEX2a, HEX1a, HEX0a};
  assign hexb_w = {HEX5b, HEX4b, HEX3b, HEX2b, HEX1b, HEX0b};

  hex_entry_ctrl #(.DEBOUNCE_CYCLES(4), .TOGGLE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .sw_nibble(sw_nibble),
    .key_load_n(key_load_n), .key_commit_n(key_commit_n), .key_clear_n(key_clear_n),
`ifdef HEX_ENTRY_BACKSPACE_EN
    .key_back_n(key_back_n),
`endif
    .auto_sel(auto_sel),
    .HEX0a(HEX0a), .HEX1a(HEX1a), .HEX2a(HEX2a), .HEX3a(HEX3a), .HEX4a(HEX4a), .HEX5a(HEX5a),
    .HEX0b(HEX0b), .HEX1b(HEX1b), .HEX2b(HEX2b), .HEX3b(HEX3b), .HEX4b(HEX4b), .HEX5b(HEX5b),
    .select(select), .value_out(value_out), .value_valid(value_valid),
    .digit_count(digit_count), .full(full)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vv_cnt = 0;
  always @(negedge clk) if (value_valid === 1'b1) vv_cnt <= vv_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: press one or more keys long enough to debounce, then release and settle
  task automatic press(input int op, input logic [3:0] nib);
    @(negedge clk);
    sw_nibble = nib;
    case (op)
      OP_LOAD:   key_load_n = 1'b0;
      OP_COMMIT: key_commit_n = 1'b0;
      OP_CLEAR:  key_clear_n = 1'b0;
      OP_CLRCM:  begin key_clear_n = 1'b0; key_commit_n = 1'b0; end
      default:   key_back_n = 1'b0;
    endcase
    repeat (HOLD) @(negedge clk);
    key_load_n = 1'b1; key_commit_n = 1'b1; key_clear_n = 1'b1; key_back_n = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  typedef struct {
    int          op;
    logic [3:0]  nib;
    logic [23:0] exp_entry;
    logic [2:0]  exp_cnt;
    logic        exp_full;
    logic [23:0] exp_value;
    int          exp_vv;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int vv0;
    int t[3];
    int n;
    logic prev;
    logic seen;

    vecs[0]  = '{OP_LOAD,   4'h1, 24'h000001, 3'd1, 1'b0, 24'h000000, 0};
    vecs[1]  = '{OP_LOAD,   4'h2, 24'h000012, 3'd2, 1'b0, 24'h000000, 0};
    vecs[2]  = '{OP_LOAD,   4'h3, 24'h000123, 3'd3, 1'b0, 24'h000000, 0};
    vecs[3]  = '{OP_CLEAR,  4'h9, 24'h000000, 3'd0, 1'b0, 24'h000000, 0};
    vecs[4]  = '{OP_COMMIT, 4'h9, 24'h000000, 3'd0, 1'b0, 24'h000000, 1};
    vecs[5]  = '{OP_LOAD,   4'hA, 24'h00000A, 3'd1, 1'b0, 24'h000000, 0};
    vecs[6]  = '{OP_LOAD,   4'hB, 24'h0000AB, 3'd2, 1'b0, 24'h000000, 0};
    vecs[7]  = '{OP_LOAD,   4'hC, 24'h000ABC, 3'd3, 1'b0, 24'h000000, 0};
    vecs[8]  = '{OP_LOAD,   4'hD, 24'h00ABCD, 3'd4, 1'b0, 24'h000000, 0};
    vecs[9]  = '{OP_LOAD,   4'hE, 24'h0ABCDE, 3'd5, 1'b0, 24'h000000, 0};
    vecs[10] = '{OP_LOAD,   4'hF, 24'hABCDEF, 3'd6, 1'b1, 24'h000000, 0};
    vecs[11] = '{OP_LOAD,   4'h7, 24'hABCDEF, 3'd6, 1'b1, 24'h000000, 0};
    vecs[12] = '{OP_COMMIT, 4'h7, 24'h000000, 3'd0, 1'b0, 24'hABCDEF, 1};
    vecs[13] = '{OP_LOAD,   4'hB, 24'h00000B, 3'd1, 1'b0, 24'hABCDEF, 0};
    vecs[14] = '{OP_LOAD,   4'hE, 24'h0000BE, 3'd2, 1'b0, 24'hABCDEF, 0};
    vecs[15] = '{OP_LOAD,   4'hE, 24'h000BEE, 3'd3, 1'b0, 24'hABCDEF, 0};
    vecs[16] = '{OP_LOAD,   4'hF, 24'h00BEEF, 3'd4, 1'b0, 24'hABCDEF, 0};

    rst_n = 1'b0; sw_nibble = 4'h0; auto_sel = 1'b0;
    key_load_n = 1'b1; key_commit_n = 1'b1; key_clear_n = 1'b1; key_back_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_entry", hexa_w, 24'h0);
    chk("rst_value", value_out, 24'h0);
    chk("rst_hexb", hexb_w, 24'h0);
    chk("rst_count", digit_count, 3'd0);
    chk("rst_flags", {select, value_valid, full}, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      vv0 = vv_cnt;
      press(vecs[i].op, vecs[i].nib);
      chk($sformatf("v%0d_entry", i), hexa_w, vecs[i].exp_entry);
      chk($sformatf("v%0d_count", i), digit_count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_full", i), full, vecs[i].exp_full);
      chk($sformatf("v%0d_value", i), value_out, vecs[i].exp_value);
      chk($sformatf("v%0d_hexb", i), hexb_w, vecs[i].exp_value);
      chk($sformatf("v%0d_vv", i), vv_cnt - vv0, vecs[i].exp_vv);
    end

    // commit 0x00BEEF in auto mode: select must be 1 in the value_valid cycle
    auto_sel = 1'b1;
    vv0 = vv_cnt;
    seen = 1'b0;
    @(negedge clk);
    key_commit_n = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (value_valid === 1'b1) begin
        seen = 1'b1;
        chk("cm_select", select, 1'b1);
        chk("cm_value", value_out, 24'h00BEEF);
        chk("cm_entry", hexa_w, 24'h0);
      end
    end
    if (!seen) chk("cm_valid_timeout", 1'b0, 1'b1);
    repeat (HOLD) @(negedge clk);
    key_commit_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("cm_vv_once", vv_cnt - vv0, 1);
    chk("cm_hexb", {HEX3b, HEX2b, HEX1b, HEX0b}, 16'hBEEF);
    chk("cm_hex45b", {HEX5b, HEX4b}, 8'h00);
    auto_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("manual_select", select, 1'b0);

    // bouncing load key: only the final steady low counts
    sw_nibble = 4'h5;
    for (int b = 0; b < 5; b++) begin
      key_load_n = 1'b0; repeat (2) @(negedge clk);
      key_load_n = 1'b1; repeat (2) @(negedge clk);
    end
    key_load_n = 1'b0; repeat (10) @(negedge clk);
    key_load_n = 1'b1; repeat (HOLD) @(negedge clk);
    chk("bounce_count", digit_count, 3'd1);
    chk("bounce_entry", hexa_w, 24'h000005);

    // clear and commit together: clear wins, nothing committed
    vv0 = vv_cnt;
    press(OP_CLRCM, 4'h0);
    chk("cc_entry", hexa_w, 24'h0);
    chk("cc_count", digit_count, 3'd0);
    chk("cc_value", value_out, 24'h00BEEF);
    chk("cc_vv", vv_cnt - vv0, 0);

    // auto toggle period
    auto_sel = 1'b1;
    prev = select;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (select !== prev) begin
        t[n] = c;
        n++;
        prev = select;
      end
    end
    chk("toggle_seen", n, 3);
    if (n == 3) begin
      chk("toggle_half1", t[1] - t[0], 8);
      chk("toggle_half2", t[2] - t[1], 8);
    end
    auto_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("auto_off_select", select, 1'b0);

    // reset in the middle of a debounce, key held across reset release
    press(OP_LOAD, 4'h4);
    key_load_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_entry", hexa_w, 24'h0);
    chk("mid_rst_value", value_out, 24'h0);
    chk("mid_rst_hexb", hexb_w, 24'h0);
    chk("mid_rst_count", digit_count, 3'd0);
    chk("mid_rst_flags", {select, value_valid, full}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("held_no_event", digit_count, 3'd0);
    key_load_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("release_no_event", digit_count, 3'd0);
    press(OP_LOAD, 4'h9);
    chk("repress_count", digit_count, 3'd1);
    chk("repress_entry", hexa_w, 24'h000009);

`ifdef HEX_ENTRY_BACKSPACE_EN
    press(OP_CLEAR, 4'h0);
    press(OP_LOAD, 4'h1);
    press(OP_LOAD, 4'h2);
    press(OP_LOAD, 4'h3);
    chk("bk_pre", hexa_w, 24'h000123);
    press(OP_BACK, 4'h0);
    chk("bk_entry", hexa_w, 24'h000012);
    chk("bk_count", digit_count, 3'd2);
    press(OP_BACK, 4'h0);
    press(OP_BACK, 4'h0);
    chk("bk_empty", {hexa_w, 1'b0, digit_count}, {24'h0, 4'h0});
    press(OP_BACK, 4'h0);
    chk("bk_zero_entry", hexa_w, 24'h0);
    chk("bk_zero_count", digit_count, 3'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
